// File: rtl/mem_refill_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_refill_arbiter_if
//
// Purpose:
//   Bundles the three sides of the refill arbiter into one interface:
//   the icache refill client, the dcache refill/writeback client and the
//   block-burst memory port.
//
// Modports:
//   master - the arbiter's view. It owns the memory request and routes
//            beats back to the clients.
//   slave  - the surrounding environment's view: the clients plus memory.
//
// Signal summary (direction as seen by the arbiter / master modport):
//   ic_req    in   icache refill request, held until ic_done
//   ic_addr   in   icache miss address
//   ic_gnt    out  icache owns the memory port
//   ic_rvalid out  read beat valid for icache
//   ic_rdata  out  read beat data for icache
//   ic_done   out  one-cycle pulse after the final icache beat
//   dc_req    in   dcache request, held until dc_done
//   dc_we     in   1 = writeback, 0 = refill (sampled at arbitration)
//   dc_addr   in   dcache block address
//   dc_wdata  in   writeback beat data
//   dc_wready out  current dc_wdata beat consumed this cycle
//   dc_gnt    out  dcache owns the memory port
//   dc_rvalid out  read beat valid for dcache
//   dc_rdata  out  read beat data for dcache
//   dc_done   out  one-cycle pulse after the final dcache beat
//   mem_req   out  burst request to memory
//   mem_we    out  burst direction
//   mem_addr  out  block-aligned burst address
//   mem_ack   in   memory accepted the request
//   mem_rvalid in  read beat valid
//   mem_rdata in   read beat data
//   mem_wready in  memory consumed the write beat
//   mem_wdata out  write beat data
// ---------------------------------------------------------------------------
interface mem_refill_arbiter_if;

  // icache client
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_gnt;
  logic        ic_rvalid;
  logic [31:0] ic_rdata;
  logic        ic_done;

  // dcache client
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic        dc_wready;
  logic        dc_gnt;
  logic        dc_rvalid;
  logic [31:0] dc_rdata;
  logic        dc_done;

  // memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_wready;
  logic [31:0] mem_wdata;

  modport master (
    input  ic_req, ic_addr,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    input  mem_ack, mem_rvalid, mem_rdata, mem_wready,
    output ic_gnt, ic_rvalid, ic_rdata, ic_done,
    output dc_wready, dc_gnt, dc_rvalid, dc_rdata, dc_done,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ic_req, ic_addr,
    output dc_req, dc_we, dc_addr, dc_wdata,
    output mem_ack, mem_rvalid, mem_rdata, mem_wready,
    input  ic_gnt, ic_rvalid, ic_rdata, ic_done,
    input  dc_wready, dc_gnt, dc_rvalid, dc_rdata, dc_done,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_refill_arbiter.sv
// ---------------------------------------------------------------------------
// mem_refill_arbiter
//
// Purpose:
//   Shares one block-burst memory port between the icache refill path and
//   the dcache refill/writeback path. One requester is chosen, its block
//   address is aligned and presented as a burst, the per-word beats are
//   routed back to the winner, and a one-cycle done pulse closes the burst.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    mem_refill_arbiter_if.master (client and memory signals)
//
// Parameters:
//   WORDSPERBLOCK  32-bit words per burst, power of two, 2..16
//   OFFSETBITS     byte-offset bits cleared when aligning, log2(WORDSPERBLOCK*4)
//
// Optional feature:
//   MEM_REFILL_ARBITER_RR_EN - when defined, simultaneous requests are
//   resolved round-robin using a one-bit last_owner register (resets to
//   icache). When undefined, dcache always wins over icache.
// ---------------------------------------------------------------------------
module mem_refill_arbiter #(
  parameter int WORDSPERBLOCK = 4,
  parameter int OFFSETBITS    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_refill_arbiter_if.master bus
);

  localparam int                CNT_W     = (WORDSPERBLOCK > 1) ? $clog2(WORDSPERBLOCK) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(WORDSPERBLOCK - 1);
  localparam logic [31:0]       ADDR_MASK = ~((32'd1 << OFFSETBITS) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BURST,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IC,
    OWN_DC
  } owner_t;

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] beat_cnt;

  logic             ic_gnt_q;
  logic             dc_gnt_q;
  logic             ic_done_q;
  logic             dc_done_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;

  logic             pick_dc;
  logic             in_burst;
  logic             ic_reading;
  logic             dc_reading;
  logic             dc_writing;
  logic             beat_fire;

`ifdef MEM_REFILL_ARBITER_RR_EN
  // Remembers who held the port last so a tie goes to the other side.
  logic             last_owner_dc;

  // Round-robin choice: a lone requester always wins; on a tie the side
  // that did not own the previous burst wins.
  always_comb begin
    pick_dc = bus.dc_req;
    if (bus.dc_req && bus.ic_req) begin
      pick_dc = !last_owner_dc;
    end
  end
`else
  // Fixed priority: dcache wins whenever it is requesting.
  always_comb begin
    pick_dc = bus.dc_req;
  end
`endif

  // Beat routing is only live while a burst is in progress, so stray
  // memory beats in IDLE/REQ/DONE never reach a client. The icache never
  // writes, so its ownership implies a read burst.
  always_comb begin
    in_burst   = (state == BURST);
    ic_reading = in_burst && (owner == OWN_IC);
    dc_reading = in_burst && (owner == OWN_DC) && !mem_we_q;
    dc_writing = in_burst && (owner == OWN_DC) &&  mem_we_q;
    beat_fire  = (ic_reading || dc_reading) ? bus.mem_rvalid :
                 (dc_writing ? bus.mem_wready : 1'b0);
  end

  // Main arbiter FSM. All client/memory control outputs are registered
  // here; only the per-beat data path below is combinational. The done
  // pulse is raised on entry to DONE and cleared by the default on the
  // next edge, so it is exactly one cycle wide. Grant is held through DONE
  // and dropped on the way back to IDLE, which leaves at least one IDLE
  // cycle between bursts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      beat_cnt   <= '0;
      ic_gnt_q   <= 1'b0;
      dc_gnt_q   <= 1'b0;
      ic_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
`ifdef MEM_REFILL_ARBITER_RR_EN
      last_owner_dc <= 1'b0;
`endif
    end else begin
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.ic_req || bus.dc_req) begin
            state     <= REQ;
            mem_req_q <= 1'b1;
            if (pick_dc) begin
              owner      <= OWN_DC;
              dc_gnt_q   <= 1'b1;
              mem_we_q   <= bus.dc_we;
              mem_addr_q <= bus.dc_addr & ADDR_MASK;
            end else begin
              owner      <= OWN_IC;
              ic_gnt_q   <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= bus.ic_addr & ADDR_MASK;
            end
          end
        end

        REQ: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            beat_cnt  <= '0;
            state     <= BURST;
          end
        end

        BURST: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == LAST_BEAT) begin
              state     <= DONE;
              ic_done_q <= (owner == OWN_IC);
              dc_done_q <= (owner == OWN_DC);
            end
          end
        end

        DONE: begin
          state      <= IDLE;
          owner      <= OWN_NONE;
          ic_gnt_q   <= 1'b0;
          dc_gnt_q   <= 1'b0;
          mem_we_q   <= 1'b0;
          mem_addr_q <= '0;
`ifdef MEM_REFILL_ARBITER_RR_EN
          last_owner_dc <= (owner == OWN_DC);
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Registered control outputs.
  assign bus.ic_gnt   = ic_gnt_q;
  assign bus.dc_gnt   = dc_gnt_q;
  assign bus.ic_done  = ic_done_q;
  assign bus.dc_done  = dc_done_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;

  // Combinational beat path, gated by ownership and direction so the
  // non-owner always sees zeros.
  assign bus.ic_rvalid = ic_reading && bus.mem_rvalid;
  assign bus.ic_rdata  = ic_reading ? bus.mem_rdata : 32'd0;
  assign bus.dc_rvalid = dc_reading && bus.mem_rvalid;
  assign bus.dc_rdata  = dc_reading ? bus.mem_rdata : 32'd0;
  assign bus.dc_wready = dc_writing && bus.mem_wready;
  assign bus.mem_wdata = dc_writing ? bus.dc_wdata : 32'd0;

endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Shares one block-burst memory port between the instruction-cache refill path and the data-cache refill/writeback path.
- Selects one requester and presents a block-aligned burst to memory.
- Routes the per-word beats back to the winner and signals completion.
- Sits between icache_dm / the data cache and the external memory interface.

Parameters:
- WORDSPERBLOCK, 4, 32-bit words per burst; power of two, 2..16.
- OFFSETBITS, 4, byte-offset bits cleared when aligning an address; must equal log2(WORDSPERBLOCK*4).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- ic_req  in  1  icache refill request; held until ic_done.
- ic_addr  in  32  icache miss address.
- ic_gnt  out  1  icache currently owns the memory port.
- ic_rvalid  out  1  read beat valid for icache.
- ic_rdata  out  32  read beat data for icache.
- ic_done  out  1  one-cycle pulse after the final icache beat.
- dc_req  in  1  dcache request; held until dc_done.
- dc_we  in  1  1 = writeback burst, 0 = refill; sampled with dc_req at arbitration.
- dc_addr  in  32  dcache block address.
- dc_wdata  in  32  writeback beat data.
- dc_wready  out  1  current dc_wdata beat consumed this cycle.
- dc_gnt  out  1  dcache currently owns the memory port.
- dc_rvalid  out  1  read beat valid for dcache.
- dc_rdata  out  32  read beat data for dcache.
- dc_done  out  1  one-cycle pulse after the final dcache beat.
- mem_req  out  1  burst request to memory.
- mem_we  out  1  burst direction.
- mem_addr  out  32  block-aligned burst address.
- mem_ack  in  1  memory accepted the request.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  32  read beat data.
- mem_wready  in  1  memory consumed the write beat.
- mem_wdata  out  32  write beat data.

Behaviour:
- Reset (reset==0 at a clk edge): FSM=IDLE; beat counter=0; owner=none.
  - All outputs 0: mem_req, mem_we, mem_addr, all gnt, rvalid, done, dc_wready.
  - Any burst in flight is abandoned.
- FSM states: IDLE, REQ, BURST, DONE.
- IDLE:
  - If any req is high, choose winner: fixed priority, dcache over icache.
  - Latch owner, direction (icache always read) and address with bits [OFFSETBITS-1:0] cleared.
  - Go to REQ. Owner's gnt rises in the same registered update.
- REQ:
  - mem_req=1; mem_addr and mem_we held stable.
  - On mem_ack: mem_req falls next cycle, counter=0, go to BURST.
  - mem_ack in IDLE, BURST or DONE is ignored.
- BURST, read:
  - ic_rvalid/ic_rdata (or dc_*) = mem_rvalid/mem_rdata, combinational, gated by owner.
  - Non-owner rvalid stays 0.
  - Counter increments per mem_rvalid.
- BURST, write:
  - mem_wdata = dc_wdata; dc_wready = mem_wready, combinational, only while dcache owns a write.
  - Counter increments per mem_wready.
- Burst end: the beat with counter == WORDSPERBLOCK-1 moves the FSM to DONE. Beats arriving in DONE are ignored.
- DONE:
  - Owner's done=1 for exactly one cycle.
  - gnt clears; FSM returns to IDLE.
  - Earliest re-arbitration is the cycle after DONE, so at least one idle cycle separates bursts.
- Requester rules:
  - Dropping req mid-burst does not abort; the burst completes and done still pulses.
  - A req that is still high in IDLE after its done is treated as a new request.
- Address latch: ic_addr/dc_addr changes after arbitration do not affect mem_addr.
- Simultaneous requests in IDLE: the loser's gnt stays 0 and its req is held pending.

Optional Feature:
- Macro: MEM_REFILL_ARBITER_RR_EN.
- Defined:
  - Round-robin arbitration; a one-bit last_owner register resets to icache.
  - On simultaneous requests, the non-last_owner side wins.
  - last_owner updates in DONE.
- Undefined: fixed dcache-over-icache priority; no last_owner register.

Test Plan:
- icache alone: ic_req=1, ic_addr=0x0000_1234, mem_ack after 2 cycles, 4 rvalid beats 0xA0..0xA3 → mem_addr=0x0000_1230, mem_we=0; ic_rdata sequence A0..A3; ic_done pulses once; dc_rvalid never 1.
- dcache writeback: dc_req=1, dc_we=1, dc_addr=0x8000_00FC, dc_wdata 0x11..0x44, mem_wready on alternate cycles → mem_addr=0x8000_00F0; 4 dc_wready pulses; mem_wdata matches each beat; dc_done after the 4th.
- Simultaneous requests, ic_req=dc_req=1 held through both bursts:
  - Fixed priority: dcache burst, then icache burst.
  - RR_EN: dcache first (last_owner=icache at reset), then icache; repeat with both still high → dcache next.
- ic_req dropped after the 2nd beat → remaining 2 beats still routed to icache; ic_done pulses; FSM back in IDLE.
- reset=0 asserted mid-BURST after beat 1 → next cycle all outputs 0, FSM in IDLE; a following ic_req starts a fresh burst with counter 0.
- Stray mem_rvalid in IDLE and mem_ack in BURST → no rvalid forwarded, no state change, counter unaffected.
